regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data-port width.
REQ-002 SHALL have parameter NREGS, default 16, number of architectural registers (power of two, >= 2).
REQ-003 SHALL have derived localparam ADDR_W = clog2(NREGS), the width of every address port.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wr_en/wr_addr/wr_data  input  1/ADDR_W/DATA_W  writeback strobe, destination and value.
REQ-007 SHALL have ports rs_addr, rt_addr  input  ADDR_W each  read-port addresses.
REQ-008 SHALL have ports rs_data, rt_data  output  DATA_W each  registered read data.
REQ-009 SHALL have ports iss_en/iss_rd  input  1/ADDR_W  issue request and its destination register.
REQ-010 SHALL have port stall  output  1  issue hazard; issue not accepted this cycle.
REQ-011 SHALL have port busy_vec  output  NREGS  per-register pending-write bits.

Function
REQ-012 SHALL return zero for any read of register 0; writes and issues to register 0 SHALL be ignored; busy_vec[0] SHALL remain 0.
REQ-013 SHALL write wr_data into register wr_addr at the clock edge where wr_en=1, and clear busy_vec[wr_addr] at the same edge.
REQ-014 SHALL have one-cycle read latency: rs_data/rt_data at edge N+1 reflect rs_addr/rt_addr sampled at edge N.
REQ-015 SHALL drive stall combinationally = iss_en AND (eff_busy[rs_addr] OR eff_busy[rt_addr] OR eff_busy[iss_rd]), where eff_busy is defined in Configuration.
REQ-016 SHALL set busy_vec[iss_rd] at the edge where iss_en=1 and stall=0; a stalled issue SHALL change no state.
REQ-017 SHALL give set priority: accepted issue and writeback to the same register at one edge leave busy_vec bit = 1 and the register holding wr_data.
REQ-018 SHALL return identical data on both ports when rs_addr = rt_addr.
REQ-019 SHALL ignore out-of-order hazards beyond RAW/WAW; no per-register counters, one pending write per register.

Reset
REQ-020 SHALL on rst=1, immediately and independent of clk, clear all NREGS registers, busy_vec, rs_data and rt_data to 0.
REQ-021 SHALL discard any writeback or issue coinciding with reset; first update after the first rising clk edge with rst=0.

Configuration
REQ-022 SHALL honour macro REGFILE_SB_BYPASS_EN.
REQ-023 With REGFILE_SB_BYPASS_EN defined: read of wr_addr (non-zero) with wr_en=1 at the same edge SHALL return wr_data; eff_busy[i] = busy_vec[i] AND NOT (wr_en AND wr_addr = i).
REQ-024 Without REGFILE_SB_BYPASS_EN: same-edge read SHALL return the pre-write value; eff_busy = busy_vec.

Structure
REQ-025 SHALL place default DATA_W, default NREGS and the zero-register index constant in shared package core_lapido_pkg.
REQ-026 SHALL instantiate one sub-module regfile_sb_scoreboard holding busy_vec and the stall logic; storage and read ports remain in regfile_sb.

Verification
REQ-027 Reset: write r5=0xDEADBEEF, assert rst mid-cycle -> rs_data=0, busy_vec=0 immediately; read r5 after release -> 0.
REQ-028 Zero register: wr_en, wr_addr=0, wr_data=0x1234; iss_en, iss_rd=0 -> read r0 = 0, busy_vec[0]=0, stall=0.
REQ-029 RAW: issue r3 (accepted), next cycle iss_en with rs_addr=3 -> stall=1 until writeback r3=0x55; bypass build stalls 0 cycles on the writeback cycle, non-bypass 1 more cycle.
REQ-030 Bypass: wr r7=0xA5A5A5A5 with rs_addr=7 same edge -> rs_data=0xA5A5A5A5 (BYPASS_EN) or previous r7 value (no macro).
REQ-031 Set priority: r9 busy, same edge writeback r9=0x10 and accepted issue r9 -> busy_vec[9]=1, later read r9 = 0x10.
REQ-032 Parameter sweep: NREGS=32, DATA_W=64, write/read all registers with index-based patterns -> every readback matches, r0=0.

Source files
------------

// File: rtl/core_lapido_pkg.sv
// Shared core constants: default register-file geometry and the hard-wired zero register.
package core_lapido_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 16;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus combinational issue-stall.
// Optional REGFILE_SB_BYPASS_EN: a same-edge writeback hides the busy bit it clears.
module regfile_sb_scoreboard
    import core_lapido_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_wr_onehot;
    logic [NREGS-1:0] w_eff_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_next;
    logic             w_stall;

    always_comb begin
        w_wr_onehot = '0;
        if (wr_en) w_wr_onehot[wr_addr] = 1'b1;
    end

`ifdef REGFILE_SB_BYPASS_EN
    assign w_eff_busy = r_busy & ~w_wr_onehot;
`else
    assign w_eff_busy = r_busy;
`endif

    assign w_stall = iss_en & (w_eff_busy[rs_addr] | w_eff_busy[rt_addr] | w_eff_busy[iss_rd]);

    // Set after clear: an accepted issue wins over a writeback to the same register.
    always_comb begin
        w_set = '0;
        if (iss_en && !w_stall && iss_rd != ZERO_ADDR) w_set[iss_rd] = 1'b1;
        w_busy_next = (r_busy & ~w_wr_onehot) | w_set;
        w_busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_next;
    end

    assign stall    = w_stall;
    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port and a pending-write scoreboard.
// Optional REGFILE_SB_BYPASS_EN: same-edge write-to-read forwarding and busy masking.
module regfile_sb
    import core_lapido_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NREGS  = NREGS_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] w_rs_next;
    logic [DATA_W-1:0] w_rt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wr_en && wr_addr != ZERO_ADDR) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_rs_next = r_regs[rs_addr];
        w_rt_next = r_regs[rt_addr];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_en && wr_addr == rs_addr) w_rs_next = wr_data;
        if (wr_en && wr_addr == rt_addr) w_rt_next = wr_data;
`endif
        if (rs_addr == ZERO_ADDR) w_rs_next = '0;
        if (rt_addr == ZERO_ADDR) w_rt_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else begin
            r_rs_data <= w_rs_next;
            r_rt_data <= w_rt_next;
        end
    end

    assign rs_data = r_rs_data;
    assign rt_data = r_rt_data;

    regfile_sb_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors push expectations into a queue, a negedge monitor checks them.
// Expectations follow REGFILE_SB_BYPASS_EN when the bench is built with that macro.
module tb_regfile_sb;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // default-geometry instance
    logic        a_wr_en;
    logic [3:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [3:0]  a_rs_addr, a_rt_addr;
    logic [31:0] a_rs_data, a_rt_data;
    logic        a_iss_en;
    logic [3:0]  a_iss_rd;
    logic        a_stall;
    logic [15:0] a_busy;

    // NREGS=32, DATA_W=64 instance
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [63:0] b_wr_data;
    logic [4:0]  b_rs_addr, b_rt_addr;
    logic [63:0] b_rs_data, b_rt_data;
    logic        b_stall;
    logic [31:0] b_busy;

    regfile_sb u_dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rs_addr(a_rs_addr), .rt_addr(a_rt_addr),
        .rs_data(a_rs_data), .rt_data(a_rt_data),
        .iss_en(a_iss_en), .iss_rd(a_iss_rd),
        .stall(a_stall), .busy_vec(a_busy)
    );

    regfile_sb #(.DATA_W(64), .NREGS(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
        .rs_data(b_rs_data), .rt_data(b_rt_data),
        .iss_en(1'b0), .iss_rd(5'd0),
        .stall(b_stall), .busy_vec(b_busy)
    );

    localparam int K_RS = 0, K_RT = 1, K_BUSY = 2, K_STALL = 3, K_BRS = 4, K_BRT = 5, K_BBUSY = 6;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            K_RS:    return {32'd0, a_rs_data};
            K_RT:    return {32'd0, a_rt_data};
            K_BUSY:  return {48'd0, a_busy};
            K_STALL: return {63'd0, a_stall};
            K_BRS:   return b_rs_data;
            K_BRT:   return b_rt_data;
            default: return {32'd0, b_busy};
        endcase
    endfunction

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < q.size()) begin
            if (q[i].due <= cyc) begin
                total++;
                if (actual(q[i].kind) !== q[i].exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", q[i].name, actual(q[i].kind), q[i].exp, cyc);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int kind, input logic [63:0] exp, input string name, input int dly);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_rd = '0;
        a_rs_addr = '0; a_rt_addr = '0;
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'h0101_0101 * 32'(i);
        lo = 32'hCAFE_0000 | 32'(i);
        return {hi, lo};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_a();
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rs_addr = '0; b_rt_addr = '0;
        expect_at(K_RS,    64'd0, "reset_rs", 0);
        expect_at(K_RT,    64'd0, "reset_rt", 0);
        expect_at(K_BUSY,  64'd0, "reset_busy", 0);
        expect_at(K_BRS,   64'd0, "reset_b_rs", 0);
        step();
        step();
        rst = 1'b0;

        // write r5, read it back, issue r4, then async reset mid-cycle
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hDEADBEEF;
        step();
        idle_a();
        a_rs_addr = 4'd5;
        expect_at(K_RS, 64'hDEADBEEF, "read_r5", 1);
        step();
        a_iss_en = 1'b1; a_iss_rd = 4'd4;
        expect_at(K_STALL, 64'd0, "issue_r4_stall", 0);
        step();
        a_iss_en = 1'b0;
        expect_at(K_BUSY, 64'h0010, "busy_r4", 0);
        expect_at(K_RS, 64'hDEADBEEF, "hold_r5", 0);
        step();
        #2;
        rst = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hFFFF_FFFF;
        a_iss_en = 1'b1; a_iss_rd = 4'd6;
        expect_at(K_RS,   64'd0, "async_rst_rs", 0);
        expect_at(K_BUSY, 64'd0, "async_rst_busy", 0);
        step();
        rst = 1'b0;
        idle_a();
        a_rs_addr = 4'd5;
        expect_at(K_BUSY, 64'd0, "rst_discard_issue", 0);
        expect_at(K_RS, 64'd0, "r5_after_rst", 1);
        step();

        // register zero
        a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 32'h1234;
        a_iss_en = 1'b1; a_iss_rd = 4'd0;
        expect_at(K_STALL, 64'd0, "r0_stall", 0);
        step();
        idle_a();
        expect_at(K_BUSY, 64'd0, "r0_busy", 0);
        expect_at(K_RS, 64'd0, "r0_rs", 1);
        expect_at(K_RT, 64'd0, "r0_rt", 1);
        step();

        // RAW hazard on r3
        a_iss_en = 1'b1; a_iss_rd = 4'd3;
        expect_at(K_STALL, 64'd0, "raw_issue_r3", 0);
        step();
        a_iss_rd = 4'd10; a_rs_addr = 4'd3;
        expect_at(K_BUSY,  64'h0008, "raw_busy_r3", 0);
        expect_at(K_STALL, 64'd1, "raw_stall_1", 0);
        step();
        expect_at(K_STALL, 64'd1, "raw_stall_2", 0);
        expect_at(K_BUSY,  64'h0008, "raw_stalled_no_state", 0);
        step();
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'h55;
        expect_at(K_STALL, BYP ? 64'd0 : 64'd1, "raw_wb_cycle_stall", 0);
        step();
        a_wr_en = 1'b0;
        expect_at(K_BUSY,  BYP ? 64'h0400 : 64'h0000, "raw_busy_after_wb", 0);
        expect_at(K_STALL, BYP ? 64'd1 : 64'd0, "raw_post_wb_stall", 0);
        step();
        a_iss_en = 1'b0;
        expect_at(K_BUSY, 64'h0400, "raw_busy_r10", 0);
        expect_at(K_RS, 64'h55, "raw_read_r3", 1);
        step();
        idle_a();
        a_wr_en = 1'b1; a_wr_addr = 4'd10; a_wr_data = 32'h77;
        step();
        idle_a();
        expect_at(K_BUSY, 64'd0, "clear_r10", 0);

        // write-to-read forwarding on r7
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 32'h1111_1111;
        step();
        a_wr_data = 32'hA5A5A5A5; a_rs_addr = 4'd7;
        expect_at(K_RS, BYP ? 64'hA5A5A5A5 : 64'h1111_1111, "bypass_r7", 1);
        step();
        a_wr_en = 1'b0; a_rt_addr = 4'd7;
        expect_at(K_RS, 64'hA5A5A5A5, "r7_rs", 1);
        expect_at(K_RT, 64'hA5A5A5A5, "r7_rt_same", 1);
        step();

        // set priority
        idle_a();
        a_iss_en = 1'b1; a_iss_rd = 4'd9;
        expect_at(K_STALL, 64'd0, "sp_issue_r9", 0);
        step();
        a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 32'h10;
        expect_at(K_BUSY,  64'h0200, "sp_busy_r9", 0);
        expect_at(K_STALL, BYP ? 64'd0 : 64'd1, "sp_r9_stall", 0);
        step();
        a_wr_addr = 4'd11; a_wr_data = 32'h20; a_iss_rd = 4'd11;
        expect_at(K_BUSY,  BYP ? 64'h0200 : 64'h0000, "sp_busy_after_r9", 0);
        expect_at(K_STALL, 64'd0, "sp_r11_stall", 0);
        step();
        idle_a();
        a_rs_addr = 4'd9; a_rt_addr = 4'd11;
        expect_at(K_BUSY, BYP ? 64'h0A00 : 64'h0800, "sp_busy_r11", 0);
        expect_at(K_RS, 64'h10, "sp_read_r9", 1);
        expect_at(K_RT, 64'h20, "sp_read_r11", 1);
        step();

        // wide instance: fill every register, then read all back
        for (int i = 0; i < 32; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 5'(i); b_wr_data = pat(i);
            step();
        end
        b_wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            b_rs_addr = 5'(i);
            b_rt_addr = 5'(31 - i);
            expect_at(K_BRS, (i == 0) ? 64'd0 : pat(i), $sformatf("sweep_rs_r%0d", i), 1);
            expect_at(K_BRT, (i == 31) ? 64'd0 : pat(31 - i), $sformatf("sweep_rt_r%0d", 31 - i), 1);
            step();
        end
        expect_at(K_BBUSY, 64'd0, "sweep_busy", 0);
        step();
        step();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_checks: got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
